// File: rtl/exe_alu_unit.sv
// rtl/exe_alu_unit.sv - multi-cycle execute-stage ALU with valid/ready handshake
module exe_alu_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [3:0]        ctrl_q, ctrl_d;

  logic [XLEN-1:0]   imm_result;
  logic              imm_illegal;
  logic [XLEN-1:0]   shifted_acc;
  logic [SHW-1:0]    shamt;
  logic              is_shift;
  logic              accept;

  assign shamt    = op_b[SHW-1:0];
  assign is_shift = (alu_ctrl == 4'd5) || (alu_ctrl == 4'd6) || (alu_ctrl == 4'd7);
  assign accept   = (state_q == S_IDLE) && in_valid && in_ready_q && !flush;

  // Single-cycle result; shifts by zero simply pass op_a through.
  always_comb begin
    imm_result  = '0;
    imm_illegal = 1'b0;
    case (alu_ctrl)
      4'd0:                 imm_result = op_a + op_b;
      4'd1:                 imm_result = op_a - op_b;
      4'd2:                 imm_result = op_a & op_b;
      4'd3:                 imm_result = op_a | op_b;
      4'd4:                 imm_result = op_a ^ op_b;
      4'd5, 4'd6, 4'd7:     imm_result = op_a;
      default:              imm_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (ctrl_q)
      4'd5:    shifted_acc = {acc_q[XLEN-2:0], 1'b0};
      4'd6:    shifted_acc = {1'b0, acc_q[XLEN-1:1]};
      default: shifted_acc = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ctrl_d      = ctrl_q;
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
      cnt_d       = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!in_ready_q) begin
            // First edge after reset release opens the input.
            in_ready_d = 1'b1;
          end else if (accept) begin
            in_ready_d = 1'b0;
            ctrl_d     = alu_ctrl;
            cnt_d      = shamt;
            if (is_shift && (shamt != '0)) begin
              state_d = S_SHIFT;
              acc_d   = op_a;
            end else begin
              state_d     = S_DONE;
              out_valid_d = 1'b1;
              result_d    = imm_result;
              zero_d      = (imm_result == '0);
              illegal_d   = imm_illegal;
            end
          end
        end
        S_SHIFT: begin
          acc_d = shifted_acc;
          cnt_d = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            result_d    = shifted_acc;
            zero_d      = (shifted_acc == '0);
            illegal_d   = 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
        default: begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ctrl_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_exe_alu_unit.sv
// tb/tb_exe_alu_unit.sv - directed self-checking bench for exe_alu_unit
module tb_exe_alu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int passed = 0;

  exe_alu_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Drives one request starting at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = 32'hDEAD_BEEF;
    op_b     = 32'h1234_5678;
    alu_ctrl = 4'd0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 00000000", result); else passed++;
    checks++; if ({zero, illegal} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {zero, illegal}); else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0001);
    checks++; if (out_valid !== 1'b1) $display("FAIL add_out_valid: got %b want 1", out_valid); else passed++;
    checks++; if (result !== 32'h0) $display("FAIL add_result: got %h want 00000000", result); else passed++;
    checks++; if (zero !== 1'b1) $display("FAIL add_zero: got %b want 1", zero); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL add_in_ready_busy: got %b want 0", in_ready); else passed++;
    @(negedge clk);
    checks++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL add_handoff: got %b want 10", {in_ready, out_valid}); else passed++;
  endtask

  task automatic test_sub();
    out_ready = 1'b1;
    issue(4'd1, 32'd5, 32'd7);
    checks++; if (out_valid !== 1'b1) $display("FAIL sub_out_valid: got %b want 1", out_valid); else passed++;
    checks++; if (result !== 32'hFFFF_FFFE) $display("FAIL sub_result: got %h want fffffffe", result); else passed++;
    checks++; if (zero !== 1'b0) $display("FAIL sub_zero: got %b want 0", zero); else passed++;
    @(negedge clk);
  endtask

  task automatic test_shift(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                            input int k, input logic [31:0] exp);
    out_ready = 1'b1;
    issue(c, a, b);
    for (int i = 0; i < k; i++) begin
      checks++; if (out_valid !== 1'b0) $display("FAIL shift%0d_early_valid: cycle %0d got %b want 0", c, i + 1, out_valid); else passed++;
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b1) $display("FAIL shift%0d_out_valid: got %b want 1", c, out_valid); else passed++;
    checks++; if (result !== exp) $display("FAIL shift%0d_result: got %h want %h", c, result, exp); else passed++;
    checks++; if (illegal !== 1'b0) $display("FAIL shift%0d_illegal: got %b want 0", c, illegal); else passed++;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL shift%0d_in_ready: got %b want 1", c, in_ready); else passed++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(4'd4, 32'hF0F0_F0F0, 32'hFFFF_0000);
    for (int i = 0; i < 3; i++) begin
      checks++; if ({out_valid, in_ready} !== 2'b10) $display("FAIL bp_hold_hs: cycle %0d got %b want 10", i, {out_valid, in_ready}); else passed++;
      checks++; if (result !== 32'h0F0F_F0F0) $display("FAIL bp_hold_result: cycle %0d got %h want 0f0ff0f0", i, result); else passed++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL bp_release: got %b want 01", {out_valid, in_ready}); else passed++;
  endtask

  task automatic test_flush();
    logic seen;
    seen      = 1'b0;
    out_ready = 1'b1;
    issue(4'd5, 32'h1, 32'd20);
    repeat (4) begin
      seen = seen | out_valid;
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL flush_idle: got %b want 01", {out_valid, in_ready}); else passed++;
    repeat (25) begin
      seen = seen | out_valid;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) $display("FAIL flush_no_result: got %b want 0", seen); else passed++;
    in_valid = 1'b1;
    flush    = 1'b1;
    alu_ctrl = 4'd0;
    op_a     = 32'd1;
    op_b     = 32'd2;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL flush_no_accept: got %b want 01", {out_valid, in_ready}); else passed++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL flush_no_accept_later: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    issue(4'd9, 32'h1234_5678, 32'h9ABC_DEF0);
    checks++; if (out_valid !== 1'b1) $display("FAIL illegal_out_valid: got %b want 1", out_valid); else passed++;
    checks++; if (result !== 32'h0) $display("FAIL illegal_result: got %h want 00000000", result); else passed++;
    checks++; if ({zero, illegal} !== 2'b11) $display("FAIL illegal_flags: got %b want 11", {zero, illegal}); else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    out_ready = 1'b1;
    issue(4'd7, 32'h8000_0000, 32'd10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({in_ready, out_valid, zero, illegal} !== 4'b0000) $display("FAIL rst_mid_flags: got %b want 0000", {in_ready, out_valid, zero, illegal}); else passed++;
    checks++; if (result !== 32'h0) $display("FAIL rst_mid_result: got %h want 00000000", result); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL rst_mid_release: got %b want 10", {in_ready, out_valid}); else passed++;
    repeat (12) @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_lost: got %b want 0", out_valid); else passed++;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    alu_ctrl  = 4'd0;
    op_a      = 32'h0;
    op_b      = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_shift(4'd7, 32'h8000_0000, 32'h0000_0024, 4, 32'hF800_0000);
    test_shift(4'd6, 32'h8000_0000, 32'h0000_0024, 4, 32'h0800_0000);
    test_shift(4'd5, 32'h0000_0001, 32'h0000_0000, 0, 32'h0000_0001);
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
